// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: framer states, wire constants and the byte-wide CRC-32 step
// used by both the receive and transmit paths.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREA,
        ST_HEAD,
        ST_DATA,
        ST_DROP
    } eth_state_t;

    localparam logic [7:0]  PREAMBLE   = 8'h55;
    localparam logic [7:0]  SFD        = 8'hD5;
    localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

    // Non-reflected register fed LSB-first, which is the reflected-input form of the CRC.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    // Reflect and invert; the byte sent first on the wire lands in [31:24].
    function automatic logic [31:0] crc32_final(input logic [31:0] crc);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = ~crc[31-i];
        return {r[7:0], r[15:8], r[23:16], r[31:24]};
    endfunction

endpackage

// File: rtl/eth_crc32_chk.sv
// Byte-wide Ethernet CRC-32 accumulator with reload, enable and a compare against the received FCS.
module eth_crc32_chk
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [7:0]  data,
    input  logic [31:0] fcs,
    output logic        crc_ok
);

    logic [31:0] crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    crc <= CRC32_INIT;
        else if (load) crc <= CRC32_INIT;
        else if (en)   crc <= crc32_d8(crc, data);
    end

    assign crc_ok = (crc32_final(crc) == fcs);

endmodule

// File: rtl/eth_frame_rx.sv
// Receive framer: strips preamble/SFD/header/FCS, filters on destination MAC and streams the payload.
// A 4-byte window delays every post-SFD byte so the FCS never reaches the header, CRC or payload path.
module eth_frame_rx
    import eth_pkg::*;
#(
    parameter int PRE_MIN     = 7,
    parameter int MAX_PAYLOAD = 1500
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_aresetn,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    input  logic [47:0] local_mac,
    input  logic        promisc,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] eth_type,
    output logic        hdr_valid,
    output logic        frame_ok,
    output logic        frame_err
);

    localparam logic [3:0]  PRE_MIN_C = 4'(PRE_MIN);
    localparam logic [10:0] MAX_C     = 11'(MAX_PAYLOAD);

    eth_state_t        state, state_n;
    logic              idle_seen;
    logic [3:0]        pre_cnt;
    logic [3:0][7:0]   win;
    logic [2:0]        win_cnt;
    logic [3:0]        hdr_cnt;
    logic [7:0]        hold;
    logic              hold_v;
    logic [10:0]       pay_cnt;
    logic              drop_err;

    logic              shift, leave, mac_ok, crc_ok, bad;
    logic [47:0]       dst_next;
    logic              sfd_hit, hdr_done, pre_bad, cut, fr_end, drop_end;

    assign shift    = rx_tvalid && (state == ST_HEAD || state == ST_DATA);
    assign leave    = shift && (win_cnt == 3'd4);
    assign dst_next = {dst_mac[39:0], win[3]};
    assign mac_ok   = promisc || (dst_next == local_mac) || (dst_next == BCAST_MAC);
    assign bad      = !crc_ok || (pay_cnt > MAX_C);

    eth_crc32_chk u_crc (
        .clk    (s_axis_aclk),
        .rst_n  (s_axis_aresetn),
        .load   (sfd_hit),
        .en     (leave),
        .data   (win[3]),
        .fcs    (win),
        .crc_ok (crc_ok)
    );

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) state <= ST_IDLE;
        else                 state <= state_n;
    end

    always_comb begin
        state_n  = state;
        sfd_hit  = 1'b0;
        hdr_done = 1'b0;
        pre_bad  = 1'b0;
        cut      = 1'b0;
        fr_end   = 1'b0;
        drop_end = 1'b0;
        case (state)
            ST_IDLE: begin
                // idle_seen gates out a frame already in flight when reset was released
                if (rx_tvalid && idle_seen) begin
                    if (rx_tdata == PREAMBLE) state_n = ST_PREA;
                    else begin
                        state_n = ST_DROP;
                        pre_bad = 1'b1;
                    end
                end
            end
            ST_PREA: begin
                if (!rx_tvalid) begin
                    state_n = ST_IDLE;
                    cut     = 1'b1;
                end else if (rx_tdata == PREAMBLE) begin
                    state_n = ST_PREA;
                end else if (rx_tdata == SFD && pre_cnt >= PRE_MIN_C) begin
                    state_n = ST_HEAD;
                    sfd_hit = 1'b1;
                end else begin
                    state_n = ST_DROP;
                    pre_bad = 1'b1;
                end
            end
            ST_HEAD: begin
                if (!rx_tvalid) begin
                    state_n = ST_IDLE;
                    cut     = 1'b1;
                end else if (leave && hdr_cnt == 4'd5 && !mac_ok) begin
                    state_n = ST_DROP;
                end else if (leave && hdr_cnt == 4'd13) begin
                    state_n  = ST_DATA;
                    hdr_done = 1'b1;
                end
            end
            ST_DATA: begin
                if (!rx_tvalid) begin
                    state_n = ST_IDLE;
                    fr_end  = 1'b1;
                end
            end
            ST_DROP: begin
                if (!rx_tvalid) begin
                    state_n  = ST_IDLE;
                    drop_end = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            idle_seen     <= 1'b0;
            pre_cnt       <= '0;
            win           <= '0;
            win_cnt       <= '0;
            hdr_cnt       <= '0;
            hold          <= '0;
            hold_v        <= 1'b0;
            pay_cnt       <= '0;
            drop_err      <= 1'b0;
            dst_mac       <= '0;
            src_mac       <= '0;
            eth_type      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            hdr_valid     <= 1'b0;
            frame_ok      <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            hdr_valid     <= 1'b0;
            frame_ok      <= 1'b0;
            frame_err     <= 1'b0;
            idle_seen     <= !rx_tvalid;

            // The byte that moves IDLE->PREA is the first preamble byte
            if (state == ST_IDLE)
                pre_cnt <= 4'd1;
            else if (state == ST_PREA && rx_tvalid && rx_tdata == PREAMBLE && pre_cnt != 4'hF)
                pre_cnt <= pre_cnt + 4'd1;

            if (shift) begin
                win <= {win[2:0], rx_tdata};
                if (win_cnt != 3'd4) win_cnt <= win_cnt + 3'd1;
            end

            if (sfd_hit) begin
                win_cnt  <= '0;
                hdr_cnt  <= '0;
                hold_v   <= 1'b0;
                pay_cnt  <= '0;
                drop_err <= 1'b0;
            end
            if (pre_bad) drop_err <= 1'b1;

            if (leave && state == ST_HEAD) begin
                hdr_cnt <= hdr_cnt + 4'd1;
                if (hdr_cnt < 4'd6)       dst_mac  <= dst_next;
                else if (hdr_cnt < 4'd12) src_mac  <= {src_mac[39:0], win[3]};
                else                      eth_type <= {eth_type[7:0], win[3]};
            end

            // The held byte only goes out once we know it is not the last one
            if (leave && state == ST_DATA) begin
                hold   <= win[3];
                hold_v <= 1'b1;
                if (pay_cnt != 11'h7FF) pay_cnt <= pay_cnt + 11'd1;
                if (hold_v) begin
                    m_axis_tdata  <= hold;
                    m_axis_tvalid <= 1'b1;
                end
            end

            if (hdr_done) hdr_valid <= 1'b1;

            if (fr_end) begin
                hold_v  <= 1'b0;
                pay_cnt <= '0;
                if (hold_v) begin
                    m_axis_tdata  <= hold;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= 1'b1;
                    m_axis_tuser  <= bad;
                    frame_ok      <= !bad;
                    frame_err     <= bad;
                end else begin
                    frame_err <= 1'b1;
                end
            end

            if (cut || (drop_end && drop_err)) frame_err <= 1'b1;
        end
    end

endmodule
